// File: rtl/sync_fifo_status.sv
// Single-clock FIFO with fill count, programmable almost-full/almost-empty and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads (r_data shows the head word combinationally).
module sync_fifo_status #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int AFULL_THRESH  = 14,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);

  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
    $error("sync_fifo_status: AFULL_THRESH must be in 1..DEPTH");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
    $error("sync_fifo_status: AEMPTY_THRESH must be in 0..DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wptr;
  logic [ADDR_WIDTH:0]   rptr;
  logic                  wr_acc;
  logic                  rd_acc;

  // Request/accept: a write is taken only when not full, a read only when not
  // empty; a refused request is dropped (no retry) and only marks the sticky flag.
  assign wr_acc = w_en && !full;
  assign rd_acc = r_en && !empty;

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AFULL_C);
  assign almost_empty = (count <= AEMPTY_C);

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr[ADDR_WIDTH-1:0]] <= w_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) rptr <= rptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A new error in the clearing cycle must not be lost.
      if (w_en && full)  overflow <= 1'b1;
      else if (err_clr)  overflow <= 1'b0;
      if (r_en && empty) underflow <= 1'b1;
      else if (err_clr)  underflow <= 1'b0;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign r_data = mem[rptr[ADDR_WIDTH-1:0]];
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_data <= '0;
    else if (rd_acc) r_data <= mem[rptr[ADDR_WIDTH-1:0]];
  end
`endif

endmodule

// File: tb/tb_sync_fifo_status.sv
// Directed, table-driven bench for sync_fifo_status (DATA_WIDTH=8, ADDR_WIDTH=4, AFULL=14, AEMPTY=2).
module tb_sync_fifo_status;

  localparam int DW = 8;
  localparam int AW = 4;
`ifdef SYNC_FIFO_FWFT_EN
  localparam bit FWFT = 1'b1;
`else
  localparam bit FWFT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          w_en = 1'b0;
  logic          r_en = 1'b0;
  logic          err_clr = 1'b0;
  logic [DW-1:0] w_data = '0;
  logic [DW-1:0] r_data;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;
  logic [AW:0]   count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          w;
    logic [DW-1:0] wd;
    logic          r;
    logic          clr;
    logic [AW:0]   cnt;
    logic          ov;
    logic          un;
    logic [DW-1:0] rd;
  } vec_t;

  vec_t vecs[$];

  sync_fifo_status #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(14), .AEMPTY_THRESH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .w_data(w_data), .r_en(r_en),
    .r_data(r_data), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow),
    .underflow(underflow), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  function automatic void add(input logic w, input int wd, input logic r, input logic clr,
                              input int cnt, input logic ov, input logic un, input int rd);
    vec_t v;
    v.w = w; v.wd = DW'(wd); v.r = r; v.clr = clr;
    v.cnt = (AW + 1)'(cnt); v.ov = ov; v.un = un; v.rd = DW'(rd);
    vecs.push_back(v);
  endfunction

  task automatic check_flags(input int idx, input int cnt, input logic ov, input logic un);
    check("count", idx, 32'(count), 32'(cnt));
    check("full", idx, 32'(full), 32'(cnt == 16));
    check("empty", idx, 32'(empty), 32'(cnt == 0));
    check("almost_full", idx, 32'(almost_full), 32'(cnt >= 14));
    check("almost_empty", idx, 32'(almost_empty), 32'(cnt <= 2));
    check("overflow", idx, 32'(overflow), 32'(ov));
    check("underflow", idx, 32'(underflow), 32'(un));
  endtask

  task automatic apply(input int idx, input vec_t v);
    w_en = v.w; w_data = v.wd; r_en = v.r; err_clr = v.clr;
    @(posedge clk); #1;
    w_en = 1'b0; r_en = 1'b0; err_clr = 1'b0;
    check_flags(idx, int'(v.cnt), v.ov, v.un);
    if (!FWFT) check("r_data", idx, 32'(r_data), 32'(v.rd));
  endtask

  initial begin
    // Fill 0x01..0x10, then a rejected 0x11.
    for (int i = 1; i <= 16; i++) add(1, i, 0, 0, i, 0, 0, 0);
    add(1, 8'h11, 0, 0, 16, 1, 0, 0);
    // Drain 16 words, then an underflowing read.
    for (int i = 1; i <= 16; i++) add(0, 0, 1, 0, 16 - i, 1, 0, i);
    add(0, 0, 1, 0, 0, 1, 1, 8'h10);
    add(0, 0, 1, 1, 0, 0, 1, 8'h10);
    add(0, 0, 0, 1, 0, 0, 0, 8'h10);
    // Simultaneous access at count 8.
    for (int i = 0; i < 8; i++) add(1, 8'h30 + i, 0, 0, i + 1, 0, 0, 8'h10);
    for (int i = 0; i < 4; i++) add(1, 8'h38 + i, 1, 0, 8, 0, 0, 8'h30 + i);
    for (int i = 0; i < 4; i++) add(0, 0, 1, 0, 7 - i, 0, 0, 8'h34 + i);
    // Back to full, then write+read while full.
    for (int i = 0; i < 12; i++) add(1, 8'h40 + i, 0, 0, 5 + i, 0, 0, 8'h37);
    add(1, 8'hEE, 1, 0, 15, 1, 0, 8'h38);
    for (int i = 0; i < 3; i++) add(0, 0, 1, 0, 14 - i, 1, 0, 8'h39 + i);
    for (int i = 0; i < 12; i++) add(0, 0, 1, 0, 11 - i, 1, 0, 8'h40 + i);
    // Write+read while empty.
    add(1, 8'h55, 1, 0, 1, 1, 1, 8'h4B);
    add(0, 0, 1, 0, 0, 1, 1, 8'h55);
    add(0, 0, 0, 1, 0, 0, 0, 8'h55);
    // Wrap-around: 40 words 0x20..0x47 streamed through at count 1.
    add(1, 8'h20, 0, 0, 1, 0, 0, 8'h55);
    for (int j = 1; j < 40; j++) add(1, 8'h20 + j, 1, 0, 1, 0, 0, 8'h20 + j - 1);
    add(0, 0, 1, 0, 0, 0, 0, 8'h47);

    // Power-on reset, asserted asynchronously.
    #2 rst_n = 1'b0;
    #2;
    check_flags(-1, 0, 0, 0);
    check("r_data", -1, 32'(r_data), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

`ifdef SYNC_FIFO_FWFT_EN
    // Head word visible the cycle after writing into an empty FIFO.
    w_en = 1'b1; w_data = 8'hA1;
    @(posedge clk); #1;
    w_en = 1'b0;
    check("fwft_empty", 1000, 32'(empty), 32'h0);
    check("fwft_r_data", 1000, 32'(r_data), 32'hA1);
    r_en = 1'b1;
    @(posedge clk); #1;
    r_en = 1'b0;
    check("fwft_pop_empty", 1001, 32'(empty), 32'h1);
`else
    // One-cycle latency: data arrives with the edge of the accepted read, not before.
    w_en = 1'b1; w_data = 8'hA1;
    @(posedge clk); #1;
    w_en = 1'b0;
    check("std_hold_r_data", 1000, 32'(r_data), 32'h47);
    r_en = 1'b1;
    @(posedge clk); #1;
    r_en = 1'b0;
    check("std_read_r_data", 1001, 32'(r_data), 32'hA1);
`endif

    // Mid-cycle reset with non-idle state (underflow set, one word stored).
    r_en = 1'b1;
    @(posedge clk); #1;
    r_en = 1'b0;
    w_en = 1'b1; w_data = 8'h61;
    @(posedge clk); #1;
    w_data = 8'h62;
    @(posedge clk); #1;
    w_en = 1'b0; r_en = 1'b1;
    @(posedge clk); #1;
    r_en = 1'b0;
    check_flags(2000, 1, 0, 1);
    if (!FWFT) check("pre_reset_r_data", 2000, 32'(r_data), 32'h61);
    #3 rst_n = 1'b0;
    #1;
    check_flags(2001, 0, 0, 0);
    if (!FWFT) check("reset_r_data", 2001, 32'(r_data), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_flags(2002, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
